branch_resolve_unit: RTL and testbench

- Parametrised successor to the combinational branch-condition decoder.
- Holds the architectural N/Z/V flag register and resolves conditional branches one cycle after issue.
- Keeps a PC-indexed table of 2-bit saturating predictors, compares each resolution against the fetch-time prediction, and drives a registered redirect and a multi-cycle flush window.
- Sits between the EX-stage ALU flag outputs and the fetch PC mux.

---
 rtl/branch_resolve_if.sv | 57 +++++
 rtl/branch_resolve_unit.sv | 209 ++++++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_resolve_if.sv
// branch_resolve_if: bundle between the EX stage / fetch unit and the
// branch resolve unit. The master side supplies ALU flags, the resolving
// branch and the fetch PC. The slave side (branch_resolve_unit) returns
// the prediction, the resolution, the redirect and the flush window.
interface branch_resolve_if #(
  parameter int PC_WIDTH = 16
);

  // ALU flag write path
  logic                flag_we;
  logic                n_in;
  logic                z_in;
  logic                v_in;

  // Branch in the resolve stage
  logic                br_valid;
  logic [2:0]          br_op;
  logic [PC_WIDTH-1:0] br_pc;
  logic [PC_WIDTH-1:0] br_target;
  logic                br_pred_taken;

  // Fetch-side lookup
  logic [PC_WIDTH-1:0] fetch_pc;
  logic                pred_taken;

  // Resolution results
  logic                PCSrc;
  logic                mispredict;
  logic [PC_WIDTH-1:0] redirect_pc;
  logic                flush;

  // Architectural flags
  logic                N;
  logic                Z;
  logic                V;

  // Pipeline side: drives flags, branches and fetch PC
  modport master (
    output flag_we, n_in, z_in, v_in,
    output br_valid, br_op, br_pc, br_target, br_pred_taken,
    output fetch_pc,
    input  pred_taken,
    input  PCSrc, mispredict, redirect_pc, flush,
    input  N, Z, V
  );

  // Resolve unit side
  modport slave (
    input  flag_we, n_in, z_in, v_in,
    input  br_valid, br_op, br_pc, br_target, br_pred_taken,
    input  fetch_pc,
    output pred_taken,
    output PCSrc, mispredict, redirect_pc, flush,
    output N, Z, V
  );

endinterface

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: holds the N/Z/V flag register, resolves conditional
// branches one cycle after issue, checks them against the fetch-time
// prediction and produces a registered redirect plus a flush window of
// FLUSH_CYCLES cycles after every mispredict.
//
// Build option BRANCH_BHT_EN: when defined, a BHT_DEPTH-entry table of 2-bit
// saturating counters supplies pred_taken for fetch_pc. When undefined no
// table exists and pred_taken is a static not-taken (0).
//
// Parameter constraints: BHT_DEPTH a power of two >= 2, FLUSH_CYCLES 1..15.
module branch_resolve_unit #(
  parameter int PC_WIDTH     = 16,
  parameter int BHT_DEPTH    = 16,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  branch_resolve_if.slave  bus
);

  localparam int         IDX        = $clog2(BHT_DEPTH);
  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  typedef enum logic [2:0] {
    OP_BNEQ    = 3'b000,
    OP_BEQ     = 3'b001,
    OP_BGT     = 3'b010,
    OP_BLT     = 3'b011,
    OP_BGTE    = 3'b100,
    OP_BLTE    = 3'b101,
    OP_BOVFL   = 3'b110,
    OP_BUNCOND = 3'b111
  } br_op_e;

  typedef enum logic {
    FL_IDLE   = 1'b0,
    FL_ACTIVE = 1'b1
  } flush_state_e;

  // Flag register
  logic                flag_n_q;
  logic                flag_z_q;
  logic                flag_v_q;

  // Condition evaluation
  logic                eval_n;
  logic                eval_z;
  logic                eval_v;
  logic                taken;
  logic                accept;
  logic                mispredict_d;

  // Registered resolution outputs
  logic                pcsrc_q;
  logic                mispredict_q;
  logic [PC_WIDTH-1:0] redirect_q;
  logic [PC_WIDTH-1:0] fallthrough_pc;

  // Flush window FSM
  flush_state_e        state_q;
  flush_state_e        state_d;
  logic [3:0]          cnt_q;
  logic [3:0]          cnt_d;

  // Only the low index bits of fetch_pc feed the table; the rest is
  // deliberately unused here.
  logic                unused_fetch_pc;
  assign unused_fetch_pc = ^bus.fetch_pc;

  // A branch is only looked at while no flush window is open; anything that
  // arrives during the window belongs to the squashed path.
  assign accept         = bus.br_valid & (state_q == FL_IDLE);
  assign fallthrough_pc = bus.br_pc + PC_WIDTH'(1);

  // Architectural flag register, written by the ALU strobe
  // NOTE: sequential state is assigned with <= so every register samples the
  // pre-edge values of its inputs regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      flag_n_q <= 1'b0;
      flag_z_q <= 1'b0;
      flag_v_q <= 1'b0;
    end else if (bus.flag_we) begin
      flag_n_q <= bus.n_in;
      flag_z_q <= bus.z_in;
      flag_v_q <= bus.v_in;
    end
  end

  // Forward incoming ALU flags when they are written in the same cycle
  always_comb begin
    eval_n = bus.flag_we ? bus.n_in : flag_n_q;
    eval_z = bus.flag_we ? bus.z_in : flag_z_q;
    eval_v = bus.flag_we ? bus.v_in : flag_v_q;
  end

  // Decode the condition code against the evaluation flags
  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    taken = 1'b0;
    case (br_op_e'(bus.br_op))
      OP_BNEQ:    taken = ~eval_z;
      OP_BEQ:     taken = eval_z;
      OP_BGT:     taken = ~eval_z & ~eval_n;
      OP_BLT:     taken = eval_n;
      OP_BGTE:    taken = ~eval_n;
      OP_BLTE:    taken = eval_n | eval_z;
      OP_BOVFL:   taken = eval_v;
      OP_BUNCOND: taken = 1'b1;
      default:    taken = 1'b0;
    endcase
  end

  assign mispredict_d = accept & (taken != bus.br_pred_taken);

  // Register the resolution one cycle after issue
  always_ff @(posedge clk) begin
    if (rst) begin
      pcsrc_q      <= 1'b0;
      mispredict_q <= 1'b0;
      redirect_q   <= '0;
    end else begin
      pcsrc_q      <= accept & taken;
      mispredict_q <= mispredict_d;
      if (accept) begin
        redirect_q <= taken ? bus.br_target : fallthrough_pc;
      end
    end
  end

  // Flush FSM state and down-counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FL_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Open the window on a mispredict, close it once the counter runs out
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      FL_IDLE: begin
        if (mispredict_d) begin
          state_d = FL_ACTIVE;
          cnt_d   = FLUSH_LOAD;
        end
      end
      FL_ACTIVE: begin
        if (cnt_q == 4'd0) begin
          state_d = FL_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = FL_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

`ifdef BRANCH_BHT_EN
  logic [1:0]     bht_q [BHT_DEPTH];
  logic [IDX-1:0] upd_idx;
  logic [IDX-1:0] rd_idx;

  assign upd_idx = bus.br_pc[IDX-1:0];
  assign rd_idx  = bus.fetch_pc[IDX-1:0];

  // Train the indexed counter on every accepted branch, saturating both ways
  // NOTE: the table is reset entry by entry because a known weakly-not-taken
  // start state is architecturally visible through pred_taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        bht_q[i] <= 2'b01;
      end
    end else if (accept) begin
      if (taken && (bht_q[upd_idx] != 2'b11)) begin
        bht_q[upd_idx] <= bht_q[upd_idx] + 2'b01;
      end else if (!taken && (bht_q[upd_idx] != 2'b00)) begin
        bht_q[upd_idx] <= bht_q[upd_idx] - 2'b01;
      end
    end
  end

  // Lookup reads the registered table, so a same-index update this cycle is
  // not yet visible
  assign bus.pred_taken = bht_q[rd_idx][1];
`else
  // Static not-taken prediction
  assign bus.pred_taken = 1'b0;
`endif

  assign bus.PCSrc       = pcsrc_q;
  assign bus.mispredict  = mispredict_q;
  assign bus.redirect_pc = redirect_q;
  assign bus.flush       = (state_q == FL_ACTIVE);
  assign bus.N           = flag_n_q;
  assign bus.Z           = flag_z_q;
  assign bus.V           = flag_v_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: directed bench for branch_resolve_unit. A table of
// single-branch vectors covers every condition code, forwarding and the
// register path; hand-written sequences cover flush timing, PC wrap,
// predictor saturation, flush masking and reset during a flush window.
module tb_branch_resolve_unit;

  localparam int PCW = 16;

`ifdef BRANCH_BHT_EN
  localparam logic BHT_ON = 1'b1;
`else
  localparam logic BHT_ON = 1'b0;
`endif

  typedef struct {
    logic        fw;
    logic        n;
    logic        z;
    logic        v;
    logic        valid;
    logic [2:0]  op;
    logic [15:0] pc;
    logic [15:0] tgt;
    logic        pred;
    logic        e_pcsrc;
    logic        e_misp;
    logic [15:0] e_redir;
    logic [2:0]  e_nzv;
  } vec_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  vec_t vecs [17];

  branch_resolve_if #(.PC_WIDTH(PCW)) bus ();

  branch_resolve_unit #(
    .PC_WIDTH    (PCW),
    .BHT_DEPTH   (16),
    .FLUSH_CYCLES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "time limit");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic fw, input logic n, input logic z, input logic v,
                       input logic valid, input logic [2:0] op, input logic [15:0] pc,
                       input logic [15:0] tgt, input logic pred);
    bus.flag_we       = fw;
    bus.n_in          = n;
    bus.z_in          = z;
    bus.v_in          = v;
    bus.br_valid      = valid;
    bus.br_op         = op;
    bus.br_pc         = pc;
    bus.br_target     = tgt;
    bus.br_pred_taken = pred;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 16'h0000, 16'h0000, 1'b0);
  endtask

  // Branch with flags taken from the register
  task automatic branch(input logic [2:0] op, input logic [15:0] pc,
                        input logic [15:0] tgt, input logic pred);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, op, pc, tgt, pred);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    step();
    step();
    rst = 1'b0;
  endtask

  function automatic vec_t mk(input logic fw, input logic n, input logic z, input logic v,
                              input logic valid, input logic [2:0] op, input logic [15:0] pc,
                              input logic [15:0] tgt, input logic pred, input logic e_pcsrc,
                              input logic e_misp, input logic [15:0] e_redir,
                              input logic [2:0] e_nzv);
    vec_t r;
    r.fw = fw; r.n = n; r.z = z; r.v = v; r.valid = valid; r.op = op;
    r.pc = pc; r.tgt = tgt; r.pred = pred; r.e_pcsrc = e_pcsrc;
    r.e_misp = e_misp; r.e_redir = e_redir; r.e_nzv = e_nzv;
    return r;
  endfunction

  initial begin
    total = 0;
    bad   = 0;
    bus.fetch_pc = 16'h0000;

    //            fw    n     z     v     valid op      pc        tgt       pred  pcsrc misp  redir     nzv
    vecs[0]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 16'h0100, 16'h0200, 1'b1, 1'b1, 1'b0, 16'h0200, 3'b000);
    vecs[1]  = mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3'b000, 16'h0100, 16'h0200, 1'b1, 1'b0, 1'b1, 16'h0101, 3'b010);
    vecs[2]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b001, 16'h0120, 16'h0300, 1'b1, 1'b1, 1'b0, 16'h0300, 3'b010);
    vecs[3]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'b010, 16'h0130, 16'h0050, 1'b0, 1'b1, 1'b1, 16'h0050, 3'b000);
    vecs[4]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'b010, 16'h0131, 16'h0055, 1'b0, 1'b0, 1'b0, 16'h0132, 3'b100);
    vecs[5]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b011, 16'h0140, 16'h0A00, 1'b1, 1'b1, 1'b0, 16'h0A00, 3'b100);
    vecs[6]  = mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 3'b011, 16'h0141, 16'h0A10, 1'b1, 1'b0, 1'b1, 16'h0142, 3'b011);
    vecs[7]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'b100, 16'h0150, 16'h1234, 1'b0, 1'b1, 1'b1, 16'h1234, 3'b011);
    vecs[8]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'b100, 16'h0151, 16'h1240, 1'b0, 1'b0, 1'b0, 16'h0152, 3'b100);
    vecs[9]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b101, 16'h0160, 16'hBEEF, 1'b1, 1'b1, 1'b0, 16'hBEEF, 3'b100);
    vecs[10] = mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3'b101, 16'h0161, 16'h0ABC, 1'b0, 1'b1, 1'b1, 16'h0ABC, 3'b010);
    vecs[11] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'b101, 16'h0162, 16'h0ACC, 1'b0, 1'b0, 1'b0, 16'h0163, 3'b000);
    vecs[12] = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'b110, 16'h0170, 16'h7777, 1'b1, 1'b1, 1'b0, 16'h7777, 3'b001);
    vecs[13] = mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 3'b110, 16'h0171, 16'h7788, 1'b1, 1'b0, 1'b1, 16'h0172, 3'b110);
    vecs[14] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b111, 16'hFFFF, 16'h0001, 1'b0, 1'b1, 1'b1, 16'h0001, 3'b110);
    vecs[15] = mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'b111, 16'h0180, 16'h0999, 1'b0, 1'b0, 1'b0, 16'h0001, 3'b111);
    vecs[16] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 16'h0200, 16'h0900, 1'b0, 1'b0, 1'b0, 16'h0201, 3'b111);

    // ---------------- reset values ----------------
    do_reset();
    #1;
    check("rst_pcsrc", 32'(bus.PCSrc), 32'd0);
    check("rst_misp", 32'(bus.mispredict), 32'd0);
    check("rst_redirect", 32'(bus.redirect_pc), 32'd0);
    check("rst_flush", 32'(bus.flush), 32'd0);
    check("rst_nzv", 32'({bus.N, bus.Z, bus.V}), 32'd0);
    for (int i = 0; i < 16; i++) begin
      bus.fetch_pc = 16'(i);
      #1;
      check($sformatf("rst_pred_%0d", i), 32'(bus.pred_taken), 32'd0);
    end

    // ---------------- forwarding + flush length ----------------
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3'b001, 16'h0010, 16'h0040, 1'b0);
    step();
    check("fwd_pcsrc", 32'(bus.PCSrc), 32'd1);
    check("fwd_misp", 32'(bus.mispredict), 32'd1);
    check("fwd_redirect", 32'(bus.redirect_pc), 32'h0040);
    check("fwd_flush1", 32'(bus.flush), 32'd1);
    check("fwd_z", 32'(bus.Z), 32'd1);
    idle();
    step();
    check("fwd_misp_pulse", 32'(bus.mispredict), 32'd0);
    check("fwd_flush2", 32'(bus.flush), 32'd1);
    step();
    check("fwd_flush3", 32'(bus.flush), 32'd0);

    // ---------------- correct not-taken with PC wrap ----------------
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 16'h0000, 16'h0000, 1'b0);
    step();
    check("wrap_zclr", 32'(bus.Z), 32'd0);
    branch(3'b001, 16'hFFFF, 16'h0500, 1'b0);
    step();
    check("wrap_pcsrc", 32'(bus.PCSrc), 32'd0);
    check("wrap_misp", 32'(bus.mispredict), 32'd0);
    check("wrap_flush", 32'(bus.flush), 32'd0);
    check("wrap_redirect", 32'(bus.redirect_pc), 32'h0000);
    idle();
    step();

    // ---------------- table of single branches ----------------
    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].fw, vecs[i].n, vecs[i].z, vecs[i].v, vecs[i].valid,
            vecs[i].op, vecs[i].pc, vecs[i].tgt, vecs[i].pred);
      step();
      check($sformatf("vec%0d_pcsrc", i), 32'(bus.PCSrc), 32'(vecs[i].e_pcsrc));
      check($sformatf("vec%0d_misp", i), 32'(bus.mispredict), 32'(vecs[i].e_misp));
      check($sformatf("vec%0d_redirect", i), 32'(bus.redirect_pc), 32'(vecs[i].e_redir));
      check($sformatf("vec%0d_flush", i), 32'(bus.flush), 32'(vecs[i].e_misp));
      check($sformatf("vec%0d_nzv", i), 32'({bus.N, bus.Z, bus.V}), 32'(vecs[i].e_nzv));
      idle();
      step();
      step();
      check($sformatf("vec%0d_flush_end", i), 32'(bus.flush), 32'd0);
    end

    // ---------------- predictor saturation (index 3, aliased fetch) ----------------
    do_reset();
    bus.fetch_pc = 16'h0013;
    branch(3'b111, 16'h0003, 16'h0100, 1'b1);
    #1;
    check("sat_same_cycle_pre", 32'(bus.pred_taken), 32'd0);
    step();
    check("sat_inc1", 32'(bus.pred_taken), 32'(BHT_ON));
    step();
    step();
    check("sat_inc3", 32'(bus.pred_taken), 32'(BHT_ON));
    check("sat_no_flush", 32'(bus.flush), 32'd0);
    branch(3'b001, 16'h0003, 16'h0100, 1'b0);
    step();
    check("sat_dec1", 32'(bus.pred_taken), 32'(BHT_ON));
    step();
    check("sat_dec2", 32'(bus.pred_taken), 32'd0);
    step();
    check("sat_dec3", 32'(bus.pred_taken), 32'd0);
    step();
    check("sat_dec4", 32'(bus.pred_taken), 32'd0);
    branch(3'b111, 16'h0003, 16'h0100, 1'b1);
    step();
    check("sat_floor_inc1", 32'(bus.pred_taken), 32'd0);
    step();
    check("sat_floor_inc2", 32'(bus.pred_taken), 32'(BHT_ON));
    idle();
    step();

    // ---------------- branch during flush is ignored ----------------
    bus.fetch_pc = 16'h0005;
    branch(3'b111, 16'h0020, 16'h0ABC, 1'b0);
    step();
    check("mask_misp", 32'(bus.mispredict), 32'd1);
    check("mask_flush1", 32'(bus.flush), 32'd1);
    branch(3'b111, 16'h0005, 16'h0999, 1'b1);
    step();
    check("mask_pcsrc", 32'(bus.PCSrc), 32'd0);
    check("mask_misp2", 32'(bus.mispredict), 32'd0);
    check("mask_redirect", 32'(bus.redirect_pc), 32'h0ABC);
    check("mask_flush2", 32'(bus.flush), 32'd1);
    idle();
    step();
    check("mask_flush3", 32'(bus.flush), 32'd0);
    branch(3'b111, 16'h0005, 16'h0999, 1'b1);
    #1;
    check("mask_pred_unchanged", 32'(bus.pred_taken), 32'd0);
    step();
    check("mask_pred_trained", 32'(bus.pred_taken), 32'(BHT_ON));
    idle();
    step();

    // ---------------- reset during the first flush cycle ----------------
    branch(3'b111, 16'h0021, 16'h0777, 1'b0);
    step();
    check("rmid_flush1", 32'(bus.flush), 32'd1);
    rst = 1'b1;
    idle();
    step();
    rst = 1'b0;
    check("rmid_flush", 32'(bus.flush), 32'd0);
    check("rmid_misp", 32'(bus.mispredict), 32'd0);
    check("rmid_pcsrc", 32'(bus.PCSrc), 32'd0);
    check("rmid_redirect", 32'(bus.redirect_pc), 32'd0);
    branch(3'b111, 16'h0030, 16'h0044, 1'b0);
    step();
    check("rmid_accept_pcsrc", 32'(bus.PCSrc), 32'd1);
    check("rmid_accept_misp", 32'(bus.mispredict), 32'd1);
    check("rmid_accept_redirect", 32'(bus.redirect_pc), 32'h0044);
    check("rmid_accept_flush1", 32'(bus.flush), 32'd1);
    idle();
    step();
    check("rmid_accept_flush2", 32'(bus.flush), 32'd1);
    step();
    check("rmid_accept_flush3", 32'(bus.flush), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
